rom_port_arbiter: RTL and testbench

Shares the single combinational read port of the 2^14×32-bit instruction ROM between the instruction-fetch stage (IF) and the load unit (LS) of the RISC-V core. At most one request is granted per cycle and the ROM word is registered, giving a fixed 1-cycle read latency. Load requests have priority; a streak counter bounds fetch starvation. The block sits between the fetch/LSU and the ROM, and owns the ROM address bus.

---
 rtl/rom_port_arbiter_if.sv | 44 ++++
 rtl/rom_port_arbiter.sv | 116 +++++++++++
 tb/tb_rom_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if -- bundle of the fetch, load and ROM-side signals of
// the ROM read-port arbiter.
//
// Signals:
//   if_req/if_addr/if_flush  fetch request, byte address, branch redirect
//   if_gnt/if_rvalid/if_rdata fetch grant (comb), registered response
//   ls_req/ls_addr           load request and byte address
//   ls_gnt/ls_rvalid/ls_rdata/ls_err  load grant (comb), registered response
//   rom_addr/rom_data        ROM address bus (owned by arbiter), ROM word
//
// Modports:
//   slave  -- the arbiter
//   master -- the fetch/LSU/ROM environment driving the arbiter
interface rom_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  if_req, if_addr, if_flush, ls_req, ls_addr, rom_data,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
           rom_addr
  );

  modport master (
    output if_req, if_addr, if_flush, ls_req, ls_addr, rom_data,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_err,
           rom_addr
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter -- shares the single combinational read port of the
// instruction ROM between instruction fetch (IF) and the load unit (LS).
// One grant per cycle, registered ROM word (fixed 1-cycle read latency).
// Loads have priority; a saturating streak counter forces an IF grant after
// MAX_STREAK consecutive LS grants while IF is eligible.
//
// Ports:
//   clk  -- clock, all state on rising edge
//   rst  -- synchronous active-high reset
//   bus  -- rom_port_arbiter_if.slave (fetch, load and ROM signals)
//
// Optional feature macro: ROM_ALIGN_CHECK_EN
//   defined   -- misaligned LS grants return zero data and raise ls_err
//   undefined -- ls_err is always 0, unaligned loads return raw ROM bytes
module rom_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input logic               clk,
  input logic               rst,
  rom_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_CAP = SW'(MAX_STREAK);

  logic              if_ok;
  logic              ls_ok;
  logic              if_win;
  logic              ls_win;
  logic              ls_bad;
  logic [SW-1:0]     streak;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rom_addr_c;
  logic              if_rvalid_q;
  logic              ls_rvalid_q;
  logic              ls_err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  // Eligibility and fixed-priority arbitration; a saturated streak hands the
  // port to a waiting fetch even when a load is pending.
  always_comb begin
    if_ok  = bus.if_req & ~bus.if_flush & ~rst;
    ls_ok  = bus.ls_req & ~rst;
    if_win = 1'b0;
    ls_win = 1'b0;
    if (if_ok && (streak == STREAK_CAP)) begin
      if_win = 1'b1;
    end else if (ls_ok) begin
      ls_win = 1'b1;
    end else if (if_ok) begin
      if_win = 1'b1;
    end
  end

  // The ROM sees the winner's address; idle cycles keep the last one so the
  // address bus does not toggle needlessly.
  always_comb begin
    rom_addr_c = addr_q;
    if (if_win) begin
      rom_addr_c = bus.if_addr;
    end else if (ls_win) begin
      rom_addr_c = bus.ls_addr;
    end
  end

`ifdef ROM_ALIGN_CHECK_EN
  assign ls_bad = |bus.ls_addr[1:0];
`else
  assign ls_bad = 1'b0;
`endif

  // Response registers, held address and streak counter. A flushed or idle
  // fetch (if_ok low) resets the streak, so only uninterrupted waiting counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      streak      <= '0;
    end else begin
      if_rvalid_q <= if_win;
      ls_rvalid_q <= ls_win;
      ls_err_q    <= ls_win & ls_bad;
      if (if_win || ls_win) begin
        addr_q <= rom_addr_c;
      end
      if (if_win) begin
        if_rdata_q <= bus.rom_data;
      end
      if (ls_win) begin
        ls_rdata_q <= ls_bad ? '0 : bus.rom_data;
      end
      if (if_win || !if_ok) begin
        streak <= '0;
      end else if (ls_win && (streak != STREAK_CAP)) begin
        streak <= streak + SW'(1);
      end
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.ls_gnt    = ls_win;
  assign bus.rom_addr  = rom_addr_c;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.ls_err    = ls_err_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter -- directed self-checking bench for rom_port_arbiter.
// A behavioural ROM returns a 4-byte little-endian window starting at any
// byte address. Inputs change 1 time unit after the rising edge; grants are
// sampled at the falling edge and registered responses 1 unit after the
// following rising edge.
module tb_rom_port_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rom_port_arbiter_if bus ();

  rom_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ROM contents: byte value derived from its address so every word differs.
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return {rom_byte(a + 16'd3), rom_byte(a + 16'd2),
            rom_byte(a + 16'd1), rom_byte(a)};
  endfunction

  always_comb bus.rom_data = rom_word(bus.rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held with both requests high: no grants, all outputs zero, then a
  // load grant in the first cycle after reset falls.
  task automatic test_reset();
    rst = 1'b1;
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    bus.if_flush = 1'b0;
    bus.if_addr = 16'h0020;
    bus.ls_addr = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL reset_gnt cycle %0d: got %b expected 00", i, {bus.if_gnt, bus.ls_gnt});
      end
      tick();
      checks++;
      if ({bus.if_rvalid, bus.ls_rvalid, bus.ls_err, bus.if_rdata, bus.ls_rdata, bus.rom_addr} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got rv=%b%b err=%b ifd=%h lsd=%h addr=%h expected all 0",
                 i, bus.if_rvalid, bus.ls_rvalid, bus.ls_err, bus.if_rdata, bus.ls_rdata, bus.rom_addr);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.rom_addr} !== {2'b01, 16'h0030}) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: got gnt=%b addr=%h expected gnt=01 addr=0030", {bus.if_gnt, bus.ls_gnt}, bus.rom_addr);
    end
    tick();
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    checks++;
    if ({bus.if_rvalid, bus.ls_rvalid, bus.ls_rdata} !== {2'b01, rom_word(16'h0030)}) begin
      errors++;
      $display("[TB] FAIL reset_first_data: got rv=%b%b data=%h expected rv=01 data=%h",
               bus.if_rvalid, bus.ls_rvalid, bus.ls_rdata, rom_word(16'h0030));
    end
    tick();
  endtask

  // Fetch alone at consecutive word addresses: grant every cycle, data in
  // order one cycle later, rom_addr holds the last address once idle.
  task automatic test_if_only();
    logic [15:0] a;
    bus.if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(4 * i);
      bus.if_addr = a;
      @(negedge clk);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt, bus.rom_addr} !== {2'b10, a}) begin
        errors++;
        $display("[TB] FAIL if_only_gnt %0d: got gnt=%b addr=%h expected gnt=10 addr=%h", i, {bus.if_gnt, bus.ls_gnt}, bus.rom_addr, a);
      end
      tick();
      checks++;
      if ({bus.if_rvalid, bus.ls_rvalid, bus.if_rdata} !== {2'b10, rom_word(a)}) begin
        errors++;
        $display("[TB] FAIL if_only_data %0d: got rv=%b%b data=%h expected rv=10 data=%h",
                 i, bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, rom_word(a));
      end
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt, bus.rom_addr} !== {2'b00, 16'h0008}) begin
      errors++;
      $display("[TB] FAIL if_only_idle: got gnt=%b addr=%h expected gnt=00 addr=0008", {bus.if_gnt, bus.ls_gnt}, bus.rom_addr);
    end
    tick();
    checks++;
    if ({bus.if_rvalid, bus.ls_rvalid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL if_only_rvalid_drop: got %b%b expected 00", bus.if_rvalid, bus.ls_rvalid);
    end
  endtask

  // Both requesters held: LS,LS,LS,LS,IF repeating with MAX_STREAK = 4.
  task automatic test_contention();
    logic exp_if;
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    bus.if_addr = 16'h0100;
    bus.ls_addr = 16'h0200;
    for (int i = 0; i < 10; i++) begin
      exp_if = (i % 5) == 4;
      @(negedge clk);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt} !== {exp_if, ~exp_if}) begin
        errors++;
        $display("[TB] FAIL contention_gnt %0d: got %b expected %b", i, {bus.if_gnt, bus.ls_gnt}, {exp_if, ~exp_if});
      end
      tick();
      checks++;
      if ({bus.if_rvalid, bus.ls_rvalid} !== {exp_if, ~exp_if} ||
          (exp_if && bus.if_rdata !== rom_word(16'h0100)) ||
          (!exp_if && bus.ls_rdata !== rom_word(16'h0200))) begin
        errors++;
        $display("[TB] FAIL contention_data %0d: got rv=%b%b ifd=%h lsd=%h expected rv=%b%b ifd=%h lsd=%h",
                 i, bus.if_rvalid, bus.ls_rvalid, bus.if_rdata, bus.ls_rdata, exp_if, ~exp_if,
                 rom_word(16'h0100), rom_word(16'h0200));
      end
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    tick();
  endtask

  // Flush blocks the fetch grant but not an already-registered response;
  // the grant resumes as soon as flush drops.
  task automatic test_flush();
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0040;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.ls_gnt} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL flush_pre_gnt: got %b expected 10", {bus.if_gnt, bus.ls_gnt});
    end
    tick();
    bus.if_flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.if_rvalid, bus.if_rdata} !== {2'b01, rom_word(16'h0040)}) begin
      errors++;
      $display("[TB] FAIL flush_keeps_rvalid: got gnt=%b rv=%b data=%h expected gnt=0 rv=1 data=%h",
               bus.if_gnt, bus.if_rvalid, bus.if_rdata, rom_word(16'h0040));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL flush_block %0d: got gnt=%b rv=%b expected gnt=00 rv=0", i, {bus.if_gnt, bus.ls_gnt}, bus.if_rvalid);
      end
    end
    tick();
    bus.if_flush = 1'b0;
    bus.if_addr = 16'h0044;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.if_rvalid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL flush_release_gnt: got gnt=%b rv=%b expected gnt=1 rv=0", bus.if_gnt, bus.if_rvalid);
    end
    tick();
    bus.if_req = 1'b0;
    checks++;
    if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, rom_word(16'h0044)}) begin
      errors++;
      $display("[TB] FAIL flush_release_data: got rv=%b data=%h expected rv=1 data=%h", bus.if_rvalid, bus.if_rdata, rom_word(16'h0044));
    end
    tick();
  endtask

  // A flushed cycle in the middle of an LS streak clears the count, so four
  // more LS grants follow before the forced IF grant.
  task automatic test_flush_streak();
    logic [8:0] flush_seq;
    logic [8:0] if_seq;
    flush_seq = 9'b0_0000_1000;
    if_seq    = 9'b1_0000_0000;
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    bus.if_addr = 16'h0080;
    bus.ls_addr = 16'h0090;
    for (int i = 0; i < 9; i++) begin
      bus.if_flush = flush_seq[i];
      @(negedge clk);
      checks++;
      if ({bus.if_gnt, bus.ls_gnt} !== {if_seq[i], ~if_seq[i]}) begin
        errors++;
        $display("[TB] FAIL flush_streak_gnt %0d: got %b expected %b", i, {bus.if_gnt, bus.ls_gnt}, {if_seq[i], ~if_seq[i]});
      end
      tick();
    end
    bus.if_flush = 1'b0;
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    tick();
  endtask

  // Misaligned then aligned load; behaviour depends on the alignment macro.
  task automatic test_misaligned();
    logic [31:0] exp_data;
    logic        exp_err;
`ifdef ROM_ALIGN_CHECK_EN
    exp_data = 32'h0;
    exp_err  = 1'b1;
`else
    exp_data = {rom_byte(16'h0009), rom_byte(16'h0008), rom_byte(16'h0007), rom_byte(16'h0006)};
    exp_err  = 1'b0;
`endif
    bus.ls_req = 1'b1;
    bus.ls_addr = 16'h0006;
    @(negedge clk);
    checks++;
    if ({bus.ls_gnt, bus.rom_addr} !== {1'b1, 16'h0006}) begin
      errors++;
      $display("[TB] FAIL misaligned_gnt: got gnt=%b addr=%h expected gnt=1 addr=0006", bus.ls_gnt, bus.rom_addr);
    end
    tick();
    bus.ls_addr = 16'h0008;
    checks++;
    if ({bus.ls_rvalid, bus.ls_err, bus.ls_rdata} !== {1'b1, exp_err, exp_data}) begin
      errors++;
      $display("[TB] FAIL misaligned_data: got rv=%b err=%b data=%h expected rv=1 err=%b data=%h",
               bus.ls_rvalid, bus.ls_err, bus.ls_rdata, exp_err, exp_data);
    end
    tick();
    bus.ls_req = 1'b0;
    checks++;
    if ({bus.ls_rvalid, bus.ls_err, bus.ls_rdata} !== {2'b10, rom_word(16'h0008)}) begin
      errors++;
      $display("[TB] FAIL aligned_data: got rv=%b err=%b data=%h expected rv=1 err=0 data=%h",
               bus.ls_rvalid, bus.ls_err, bus.ls_rdata, rom_word(16'h0008));
    end
    tick();
    checks++;
    if ({bus.ls_rvalid, bus.ls_err} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL misaligned_idle: got rv=%b err=%b expected 00", bus.ls_rvalid, bus.ls_err);
    end
  endtask

  // Reset arriving while a load is pending: no grant, the outstanding
  // response is dropped and every output returns to zero.
  task automatic test_reset_mid();
    bus.ls_req = 1'b1;
    bus.ls_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (bus.ls_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre_gnt: got %b expected 1", bus.ls_gnt);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ls_gnt, bus.if_gnt, bus.ls_rvalid} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL reset_mid_gnt: got lsg=%b ifg=%b rv=%b expected lsg=0 ifg=0 rv=1", bus.ls_gnt, bus.if_gnt, bus.ls_rvalid);
    end
    tick();
    checks++;
    if ({bus.ls_rvalid, bus.if_rvalid, bus.ls_err, bus.ls_rdata, bus.if_rdata, bus.rom_addr} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got rv=%b%b err=%b lsd=%h ifd=%h addr=%h expected all 0",
               bus.ls_rvalid, bus.if_rvalid, bus.ls_err, bus.ls_rdata, bus.if_rdata, bus.rom_addr);
    end
    rst = 1'b0;
    bus.ls_req = 1'b0;
    tick();
  endtask

  initial begin
    clk = 1'b0;
    errors = 0;
    checks = 0;
    test_reset();
    test_if_only();
    test_contention();
    test_flush();
    test_flush_streak();
    test_misaligned();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
